// File: rtl/fifo_rd_axis_adapter.sv
// Read-side drain for a sync_fifo: issues read strobes, captures the one-cycle-late
// read data into a 2-entry skid buffer and presents it as a framed valid/ready stream.
`timescale 1ns/1ps
module fifo_rd_axis_adapter #(
  parameter int WIDTH       = 4,
  parameter int BURST_BEATS = 16,
  parameter int BCNT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rden,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic [31:0]      beat_total
);

  logic [WIDTH-1:0]  buf_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              rd_inflight;
  logic [BCNT_W-1:0] beat_cnt;
  logic              pop;
  logic [2:0]        pend_sum;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == BCNT_W'(BURST_BEATS - 1));
  assign pop     = m_valid && m_ready;
  assign busy    = (occ != 2'd0) || rd_inflight;

  // Occupancy after this cycle's capture and pop; a new read is only safe while
  // that leaves room for the data it will return next cycle.
  assign pend_sum  = {1'b0, occ} + {2'b0, rd_inflight} - {2'b0, pop};
  assign fifo_rden = rst_n && en && !fifo_empty && (pend_sum < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      rd_inflight <= 1'b0;
      beat_cnt    <= '0;
      beat_total  <= 32'd0;
    end else begin
      // Read issued this cycle returns data next cycle
      rd_inflight <= fifo_rden;
      if (rd_inflight) begin
        buf_mem[wr_ptr] <= fifo_dout;
        wr_ptr          <= ~wr_ptr;
      end
      occ <= pend_sum[1:0];
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        beat_total <= beat_total + 32'd1;
        if (m_last) beat_cnt <= '0;
        else        beat_cnt <= beat_cnt + BCNT_W'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, occ} + {2'b0, rd_inflight}) <= 3'd2);
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    rd_inflight |-> (occ != 2'd2 || pop));

endmodule

// File: doc/fifo_rd_axis_adapter.md
# fifo_rd_axis_adapter

Read-side drain stage that sits directly downstream of a `sync_fifo` instance in the ACE bridge datapath. It issues FIFO read strobes, captures the one-cycle-late FIFO read data into a 2-entry skid buffer, and presents it on a valid/ready stream with burst framing (`m_last`). Full throughput is one beat per cycle under no backpressure, with zero loss or duplication under arbitrary `m_ready` stalls.

## Interface
- `WIDTH`, 4: data width; must equal the upstream FIFO `WIDTH`.
- `BURST_BEATS`, 16: beats per burst, ≥1; `m_last` marks every `BURST_BEATS`-th accepted beat.
- `BCNT_W`, `CLOG2(BURST_BEATS)` (min 1): in-burst beat counter width, derived.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  when 0, no new FIFO reads are issued; in-flight and buffered data still drain.
- `fifo_empty`  in  1  upstream FIFO empty flag (registered in FIFO).
- `fifo_dout`  in  WIDTH  upstream FIFO read data, valid the cycle after `fifo_rden`.
- `fifo_rden`  out  1  FIFO read strobe (combinational).
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  output beat accepted when `m_valid && m_ready`.
- `m_data`  out  WIDTH  output beat data.
- `m_last`  out  1  last beat of burst.
- `busy`  out  1  `occ != 0 || rd_inflight`.
- `beat_total`  out  32  accepted-beat count, wraps at 2^32.

## Operation
- State: 2-entry buffer (`buf[0..1]`, 1-bit `wr_ptr`/`rd_ptr`), `occ` (0..2), `rd_inflight` (1 bit), `beat_cnt` (BCNT_W), `beat_total`.
- `pop = m_valid && m_ready`.
- `fifo_rden = rst_n && en && !fifo_empty && (occ + rd_inflight - pop) < 2`; arithmetic evaluated in 3 bits, no underflow since pop ⇒ occ ≥ 1.
- `rd_inflight <= fifo_rden` each cycle.
- Capture: if `rd_inflight`, `buf[wr_ptr] <= fifo_dout`, `wr_ptr` toggles.
- `occ <= occ + rd_inflight - pop`; simultaneous capture and pop leaves `occ` unchanged.
- `m_valid = (occ != 0)`; `m_data = buf[rd_ptr]`; on pop `rd_ptr` toggles.
- `m_last = m_valid && (beat_cnt == BURST_BEATS-1)`.
- On pop: `beat_cnt` wraps to 0 if `m_last`, else increments; `beat_total` increments.
- Invariant: `occ + rd_inflight ≤ 2` every cycle; a capture never overwrites an unpopped entry. This is an assertion target.
- `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- `en` falling mid-stream: the read issued in the previous cycle is still captured and delivered; no partial-burst flush; `beat_cnt` is preserved.
- `fifo_empty` is sampled the same cycle; the FIFO's registered empty flag already reflects the previous cycle's read, so a read is never issued to an empty FIFO.

## Timing
- Reset values: `m_valid` 0, `m_last` 0, `fifo_rden` 0, `m_data` 0 (buffer cleared), `busy` 0, `beat_total` 0, `beat_cnt` 0, `occ` 0, `rd_inflight` 0, pointers 0.
- Latency: `fifo_rden` in cycle N → capture at end of N+1 → `m_valid` in N+2.
- Back-to-back: with `m_ready=1`, one `fifo_rden` per cycle while the FIFO is non-empty; one beat per cycle out.
- Stall: at most 2 reads outstanding + buffered; `fifo_rden` drops the cycle the sum reaches 2 without a pop.
- Restart after stall: `fifo_rden` re-asserts in the same cycle as the first pop.
- Async reset mid-burst: all state clears immediately; a pending FIFO read result arriving after reset is discarded (`rd_inflight` = 0).

## Test plan
- Reset: assert `rst_n=0` with `fifo_empty=0`, `en=1` → `fifo_rden=0`, `m_valid=0`, `m_last=0`, `beat_total=0`, `busy=0`.
- Streaming: FIFO preloaded with 0..15, `BURST_BEATS=16`, `m_ready=1`, `en=1` → 16 consecutive `fifo_rden`; `m_valid` starts 2 cycles after the first `fifo_rden`; data 0..15 in order, one per cycle; `m_last` only on data 15; `beat_total=16`.
- Backpressure: same preload, `m_ready=0` → exactly 2 `fifo_rden` pulses then low; `m_data=0` held. Toggle `m_ready` 1/0 randomly → output sequence still 0..15, no gaps or duplicates; `occ+rd_inflight ≤ 2` throughout.
- Empty boundary: single entry 0xA → one `fifo_rden`; no rden after the FIFO goes empty; one beat 0xA; then `busy=0`.
- Enable drop: deassert `en` the cycle after the 3rd `fifo_rden` → the 3rd beat is still delivered, no further reads, `busy` falls; re-assert `en` → resumes at entry 3 with `beat_cnt=3`, `m_last` on entry 15.
- Reset mid-burst: pulse `rst_n` low after 5 beats → outputs clear; after release, the next `m_last` occurs on the 16th beat after reset.
